// File: rtl/ifm_stream_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// ifm_stream_window_ctrl_if
// Bundles the IFM streaming controller's signals: run control, IFM RAM read
// port, line-buffer push port and window/OFM indication.
//   start         run request (environment -> controller)
//   ifm_data_in   IFM RAM read data, one cycle after ifm_rd_en
//   ifm_rd_en     IFM RAM read strobe
//   ifm_addr      IFM RAM read address
//   fifo_enable   line-buffer shift enable
//   fifo_data_in  line-buffer input word
//   window_valid  line-buffer taps hold a complete KxK window
//   ofm_addr      raster index of the current window
//   busy          run in progress
//   done          one-cycle end-of-run pulse
// master: the controller side. slave: the RAM/FIFO/sequencer side.
// ---------------------------------------------------------------------------
interface ifm_stream_window_ctrl_if #(
    parameter int DATA_WIDTH            = 32,
    parameter int ADDRESS_SIZE_IFM      = 10,
    parameter int ADDRESS_SIZE_NEXT_IFM = 10
);
    logic                             start;
    logic [DATA_WIDTH-1:0]            ifm_data_in;
    logic                             ifm_rd_en;
    logic [ADDRESS_SIZE_IFM-1:0]      ifm_addr;
    logic                             fifo_enable;
    logic [DATA_WIDTH-1:0]            fifo_data_in;
    logic                             window_valid;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_addr;
    logic                             busy;
    logic                             done;

    modport master (
        input  start, ifm_data_in,
        output ifm_rd_en, ifm_addr, fifo_enable, fifo_data_in,
               window_valid, ofm_addr, busy, done
    );

    modport slave (
        output start, ifm_data_in,
        input  ifm_rd_en, ifm_addr, fifo_enable, fifo_data_in,
               window_valid, ofm_addr, busy, done
    );
endinterface

// File: rtl/ifm_stream_window_ctrl.sv
// ---------------------------------------------------------------------------
// ifm_stream_window_ctrl
// Streams one IFM channel from IFM RAM into the KxK line buffer, one pixel
// per cycle in raster order, and flags each push that completes a full,
// non-wrapped KxK window together with its OFM raster index.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-low
//   bus    ifm_stream_window_ctrl_if.master (start, RAM read, FIFO push,
//          window_valid/ofm_addr, busy/done)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// STREAM | issuing IFM RAM reads, address 0..N-1
// DRAIN  | last read data arriving, final FIFO push
// DONE   | last window flagged, done pulse
// ---------------------------------------------------------------------------
module ifm_stream_window_ctrl #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 32,
    parameter int KERNAL_SIZE           = 5,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT ** 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    ifm_stream_window_ctrl_if.master  bus
);
    localparam int POS_W = $clog2(IFM_SIZE + 1);
    localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(IFM_SIZE - 1);
    localparam logic [POS_W-1:0] K_M1     = POS_W'(KERNAL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                             rd_en_q;
    logic [ADDRESS_SIZE_IFM-1:0]      addr_q;
    logic                             fifo_en_q;
    logic                             win_q;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_addr_q;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_cnt;
    logic                             done_q;
    logic [POS_W-1:0]                 col;
    logic [POS_W-1:0]                 row;
    logic                             run_start;
    logic                             push_in_window;

    assign run_start = (state == S_IDLE) && bus.start;

    // col/row describe the pixel being pushed this cycle, so a push completes
    // a window exactly when that pixel sits at or beyond (K-1, K-1).
    assign push_in_window = fifo_en_q && (row >= K_M1) && (col >= K_M1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_STREAM;
            S_STREAM: if (addr_q == LAST_ADDR) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            fifo_en_q  <= 1'b0;
            win_q      <= 1'b0;
            ofm_addr_q <= '0;
            ofm_cnt    <= '0;
            done_q     <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else begin
            state     <= state_nxt;
            fifo_en_q <= rd_en_q;
            win_q     <= push_in_window;
            done_q    <= (state == S_DRAIN);

            if (run_start) begin
                rd_en_q <= 1'b1;
                addr_q  <= '0;
            end else if (state == S_STREAM) begin
                if (addr_q == LAST_ADDR) begin
                    rd_en_q <= 1'b0;
                end else begin
                    addr_q <= addr_q + ADDRESS_SIZE_IFM'(1);
                end
            end

            if (run_start) begin
                col <= '0;
                row <= '0;
            end else if (fifo_en_q) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + POS_W'(1);
                end else begin
                    col <= col + POS_W'(1);
                end
            end

            // ofm_addr only moves on a flagged window and holds otherwise.
            if (run_start) begin
                ofm_cnt <= '0;
            end else if (push_in_window) begin
                ofm_addr_q <= ofm_cnt;
                ofm_cnt    <= ofm_cnt + ADDRESS_SIZE_NEXT_IFM'(1);
            end
        end
    end

    assign bus.ifm_rd_en    = rd_en_q;
    assign bus.ifm_addr     = addr_q;
    assign bus.fifo_enable  = fifo_en_q;
    assign bus.fifo_data_in = bus.ifm_data_in;
    assign bus.window_valid = win_q;
    assign bus.ofm_addr     = ofm_addr_q;
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = done_q;

endmodule

// File: tb/tb_ifm_stream_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifm_stream_window_ctrl
// Two controllers (32x32/K5 and 6x6/K3) fed from a random-content RAM model.
// The reference describes every cycle of a run from its offset t after the
// accepted start: reads in 0..N-1, pushes in 1..N, pixel p=t-2 flags a window
// when its row and column are both >= K-1, done at N+1. A behavioural line
// buffer confirms each flagged window holds the right KxK pixels.
// ---------------------------------------------------------------------------
module tb_ifm_stream_window_ctrl;
    localparam int DW  = 32;
    localparam int SA  = 32;
    localparam int KA  = 5;
    localparam int SB  = 6;
    localparam int KB  = 3;
    localparam int AWA = $clog2(SA * SA);
    localparam int OWA = $clog2((SA - KA + 1) ** 2);
    localparam int AWB = $clog2(SB * SB);
    localparam int OWB = $clog2((SB - KB + 1) ** 2);
    localparam int LBD = 160;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ifm_stream_window_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_SIZE_IFM(AWA), .ADDRESS_SIZE_NEXT_IFM(OWA)) bus_a ();
    ifm_stream_window_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_SIZE_IFM(AWB), .ADDRESS_SIZE_NEXT_IFM(OWB)) bus_b ();

    ifm_stream_window_ctrl #(.DATA_WIDTH(DW), .IFM_SIZE(SA), .KERNAL_SIZE(KA)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    ifm_stream_window_ctrl #(.DATA_WIDTH(DW), .IFM_SIZE(SB), .KERNAL_SIZE(KB)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    logic [DW-1:0] ram [0:SA*SA-1];

    always @(posedge clk) begin
        if (!reset) begin
            bus_a.ifm_data_in <= '0;
            bus_b.ifm_data_in <= '0;
        end else begin
            if (bus_a.ifm_rd_en) bus_a.ifm_data_in <= ram[bus_a.ifm_addr];
            if (bus_b.ifm_rd_en) bus_b.ifm_data_in <= ram[bus_b.ifm_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // reference state per instance: offset in run (-1 = idle), held ofm index,
    // "no run since reset" flag, and the line buffer contents (index 0 newest)
    int            rt      [0:1] = '{-1, -1};
    int            exp_ofm [0:1] = '{0, 0};
    bit            fresh   [0:1] = '{1'b1, 1'b1};
    logic [DW-1:0] lb      [0:1][0:LBD-1];

    // per-run observations of instance A and B
    int            a_cnt, a_first, a_done_t, a_done_ofm, a_wrap_ofm, a_wrap_bad, prev_ofm;
    logic [DW-1:0] a_first_tap0;
    logic [31:0]   a_hash;
    int            b_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats(input int i);
        if (i == 0) begin
            a_cnt = 0; a_first = -1; a_done_t = -1; a_done_ofm = -1;
            a_wrap_ofm = -1; a_wrap_bad = 0; prev_ofm = -1;
            a_first_tap0 = '0; a_hash = '0;
        end else begin
            b_cnt = 0;
        end
    endtask

    task automatic step(input int i, input int n, input logic st, input logic fe, input logic [DW-1:0] fd);
        if (fe === 1'b1) begin
            for (int k = LBD - 1; k > 0; k--) lb[i][k] = lb[i][k-1];
            lb[i][0] = fd;
        end
        if (!reset) begin
            rt[i] = -1; fresh[i] = 1'b1; exp_ofm[i] = 0;
        end else if (rt[i] < 0) begin
            if (st === 1'b1) begin
                rt[i] = 0; fresh[i] = 1'b0;
                clear_stats(i);
            end
        end else begin
            rt[i] = (rt[i] == n + 1) ? -1 : rt[i] + 1;
        end
    endtask

    always @(posedge clk) begin
        step(0, SA * SA, bus_a.start, bus_a.fifo_enable, bus_a.fifo_data_in);
        step(1, SB * SB, bus_b.start, bus_b.fifo_enable, bus_b.fifo_data_in);
    end

    task automatic cmp(input int i, input int s, input int k, input string px,
                       input logic rd, input logic [63:0] addr, input logic fe,
                       input logic [63:0] fdi, input logic [63:0] din, input logic wv,
                       input logic [63:0] oa, input logic bsy, input logic dn);
        int  n, t, p, r, c, bad;
        bit  e_win;
        n = s * s; t = rt[i]; p = 0; e_win = 1'b0;
        if (t >= 2 && t <= n + 1) begin
            p = t - 2; r = p / s; c = p % s;
            e_win = (r >= k - 1) && (c >= k - 1);
            if (e_win) exp_ofm[i] = (r - k + 1) * (s - k + 1) + (c - k + 1);
        end
        chk({px, " ifm_rd_en"}, 64'(rd), 64'(t >= 0 && t < n));
        if (t >= 0 && t < n)  chk({px, " ifm_addr"}, addr, 64'(t));
        else if (fresh[i])    chk({px, " ifm_addr idle"}, addr, 64'(0));
        chk({px, " fifo_enable"}, 64'(fe), 64'(t >= 1 && t <= n));
        chk({px, " fifo_data_in"}, fdi, din);
        chk({px, " window_valid"}, 64'(wv), 64'(e_win));
        chk({px, " ofm_addr"}, oa, 64'(exp_ofm[i]));
        chk({px, " busy"}, 64'(bsy), 64'(t >= 0));
        chk({px, " done"}, 64'(dn), 64'(t == n + 1));
        if (e_win && wv === 1'b1) begin
            bad = 0;
            for (int a = 0; a < k; a++)
                for (int b = 0; b < k; b++)
                    if (lb[i][a*s+b] !== ram[p - a*s - b]) bad++;
            chk({px, " window taps bad"}, 64'(bad), 64'(0));
        end
        if (i == 0 && t >= 0) begin
            if (wv === 1'b1) begin
                a_cnt++;
                if (a_first < 0) begin
                    a_first = t;
                    a_first_tap0 = lb[0][0];
                end
                if (prev_ofm >= 0) chk("a ofm_addr step", oa, 64'(prev_ofm + 1));
                prev_ofm = int'(oa);
                a_hash = {a_hash[30:0], a_hash[31]} ^ lb[0][0] ^ 32'(oa);
                if (t >= 162 && t <= 165) a_wrap_bad++;
            end
            if (t == 166) a_wrap_ofm = (wv === 1'b1) ? int'(oa) : -1;
            if (dn === 1'b1) begin
                a_done_t = t;
                a_done_ofm = int'(oa);
            end
        end
        if (i == 1 && t >= 0) begin
            if (wv === 1'b1) b_cnt++;
            if (dn === 1'b1) begin
                chk("b windows per run", 64'(b_cnt), 64'(16));
                chk("b done cycle", 64'(t), 64'(37));
            end
        end
    endtask

    always @(negedge clk) begin
        cmp(0, SA, KA, "a", bus_a.ifm_rd_en, 64'(bus_a.ifm_addr), bus_a.fifo_enable,
            64'(bus_a.fifo_data_in), 64'(bus_a.ifm_data_in), bus_a.window_valid,
            64'(bus_a.ofm_addr), bus_a.busy, bus_a.done);
        cmp(1, SB, KB, "b", bus_b.ifm_rd_en, 64'(bus_b.ifm_addr), bus_b.fifo_enable,
            64'(bus_b.fifo_data_in), 64'(bus_b.ifm_data_in), bus_b.window_valid,
            64'(bus_b.ofm_addr), bus_b.busy, bus_b.done);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int budget);
        int n;
        n = 0;
        while (bus_a.done !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        if (bus_a.done !== 1'b1) chk("a done within budget", 64'(0), 64'(1));
    endtask

    task automatic check_full_run(input string tag, input logic [31:0] ref_hash, input bit use_hash);
        chk({tag, " window count"}, 64'(a_cnt), 64'(784));
        chk({tag, " first window cycle"}, 64'(a_first), 64'(134));
        chk({tag, " first window tap0"}, 64'(a_first_tap0), 64'(ram[132]));
        chk({tag, " done cycle"}, 64'(a_done_t), 64'(1025));
        chk({tag, " done ofm_addr"}, 64'(a_done_ofm), 64'(783));
        chk({tag, " row-wrap flags"}, 64'(a_wrap_bad), 64'(0));
        chk({tag, " ofm_addr at p=164"}, 64'(a_wrap_ofm), 64'(28));
        if (use_hash) chk({tag, " output signature"}, 64'(a_hash), 64'(ref_hash));
    endtask

    // instance B: random gaps, single pulses and held-high starts
    initial begin
        bus_b.start = 1'b0;
        @(posedge reset);
        #1;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 20)) cyc();
            bus_b.start = 1'b1;
            repeat ($urandom_range(1, 100)) begin
                cyc();
                if ($urandom_range(0, 3) == 0) bus_b.start = 1'b0;
            end
            bus_b.start = 1'b0;
        end
    end

    initial begin
        logic [31:0] h1;
        for (int k = 0; k < SA * SA; k++) ram[k] = $urandom;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < LBD; k++) lb[i][k] = '0;
        clear_stats(0);
        clear_stats(1);
        bus_a.start = 1'b0;
        reset = 1'b0;
        repeat (3) cyc();
        chk("reset busy", 64'(bus_a.busy), 64'(0));
        chk("reset ifm_rd_en", 64'(bus_a.ifm_rd_en), 64'(0));
        chk("reset ofm_addr", 64'(bus_a.ofm_addr), 64'(0));
        reset = 1'b1;
        repeat (4) cyc();

        // run 1: spurious starts in cycle 10 and in the DONE cycle 1025
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        repeat (10) cyc();
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        repeat (1014) cyc();
        chk("a done in cycle 1025", 64'(bus_a.done), 64'(1));
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        chk("a idle after run", 64'(bus_a.busy), 64'(0));
        check_full_run("run1", 32'h0, 1'b0);
        h1 = a_hash;

        // run 2: start in IDLE right after the run gives identical output
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        wait_done_a(1100);
        cyc();
        check_full_run("run2", h1, 1'b1);

        // run 3: reset asserted in cycles 500..509
        repeat ($urandom_range(0, 6)) cyc();
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        repeat (500) cyc();
        reset = 1'b0;
        repeat (5) cyc();
        chk("mid-run reset busy", 64'(bus_a.busy), 64'(0));
        chk("mid-run reset fifo_enable", 64'(bus_a.fifo_enable), 64'(0));
        repeat (5) cyc();
        reset = 1'b1;
        repeat ($urandom_range(1, 6)) cyc();

        // run 4: random start noise throughout the run
        bus_a.start = 1'b1;
        cyc();
        for (int n = 0; n < 1100 && bus_a.done !== 1'b1; n++) begin
            bus_a.start = ($urandom_range(0, 7) == 0);
            cyc();
        end
        if (bus_a.done !== 1'b1) chk("a done within budget", 64'(0), 64'(1));
        bus_a.start = 1'b0;
        cyc();
        check_full_run("run4", h1, 1'b1);

        repeat (200) cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
